// File: rtl/msg_frame_pkg.sv
// Shared types and default widths for the message framing controller.
package msg_frame_pkg;

    localparam int DEF_COUNT_BITS = 16;
    localparam int DEF_DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/msg_len_counter.sv
// Beat counter with synchronous clear/enable and a terminal-beat flag.
module msg_len_counter
    import msg_frame_pkg::*;
#(
    parameter int NUM_COUNT_BITS = DEF_COUNT_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_enable,
    input  logic [NUM_COUNT_BITS-1:0] i_terminal,
    output logic [NUM_COUNT_BITS-1:0] o_count,
    output logic                      o_is_last
);

    logic [NUM_COUNT_BITS-1:0] r_count;
    logic [NUM_COUNT_BITS:0]   w_count_plus1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // One extra bit so a terminal of all-ones never matches a wrapped count.
    assign w_count_plus1 = {1'b0, r_count} + 1'b1;
    assign o_is_last     = (w_count_plus1 == {1'b0, i_terminal});
    assign o_count       = r_count;

endmodule

// File: rtl/msg_frame_ctrl.sv
// AXI-Stream message framer: forwards cfg_len beats and marks the last one.
// Optional upstream tlast cross-check enabled by MSG_FRAME_TLAST_CHECK_EN.
module msg_frame_ctrl
    import msg_frame_pkg::*;
#(
    parameter int NUM_COUNT_BITS = DEF_COUNT_BITS,
    parameter int DATA_W         = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [NUM_COUNT_BITS-1:0] cfg_len,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    input  logic [DATA_W-1:0]         s_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic                      m_tlast,
    output logic [NUM_COUNT_BITS-1:0] beat_count,
    output logic                      busy,
    output logic                      msg_done,
    output logic                      err_zero_len
`ifdef MSG_FRAME_TLAST_CHECK_EN
    ,
    input  logic                      s_tlast,
    output logic                      err_tlast
`endif
);

    state_t                    r_state;
    logic [NUM_COUNT_BITS-1:0] r_len;
    logic                      r_busy;
    logic                      r_msg_done;
    logic                      r_err_zero_len;

    logic w_streaming;
    logic w_cfg_accept;
    logic w_cfg_zero;
    logic w_beat;
    logic w_is_last;
    logic w_final;

    assign w_streaming  = (r_state == STREAM);
    assign w_cfg_accept = (r_state == IDLE) && cfg_valid && (cfg_len != '0);
    assign w_cfg_zero   = (r_state == IDLE) && cfg_valid && (cfg_len == '0);
    assign w_beat       = w_streaming && s_tvalid && m_tready;
    assign w_final      = w_beat && w_is_last;

    msg_len_counter #(
        .NUM_COUNT_BITS (NUM_COUNT_BITS)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_cfg_accept),
        .i_enable   (w_beat),
        .i_terminal (r_len),
        .o_count    (beat_count),
        .o_is_last  (w_is_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_len          <= '0;
            r_busy         <= 1'b0;
            r_msg_done     <= 1'b0;
            r_err_zero_len <= 1'b0;
        end else begin
            r_msg_done     <= 1'b0;
            r_err_zero_len <= w_cfg_zero;
            case (r_state)
                IDLE: begin
                    if (w_cfg_accept) begin
                        r_len   <= cfg_len;
                        r_state <= STREAM;
                        r_busy  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (w_final) begin
                        r_state    <= DONE;
                        r_msg_done <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Data path is a zero-latency pass-through, gated off outside STREAM.
    assign cfg_ready    = (r_state == IDLE);
    assign s_tready     = w_streaming && m_tready;
    assign m_tvalid     = w_streaming && s_tvalid;
    assign m_tdata      = w_streaming ? s_tdata : '0;
    assign m_tlast      = m_tvalid && w_is_last;
    assign busy         = r_busy;
    assign msg_done     = r_msg_done;
    assign err_zero_len = r_err_zero_len;

`ifdef MSG_FRAME_TLAST_CHECK_EN
    logic r_err_tlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_tlast <= 1'b0;
        end else begin
            r_err_tlast <= w_beat && (s_tlast != m_tlast);
        end
    end

    assign err_tlast = r_err_tlast;
`endif

endmodule

// File: tb/tb_msg_frame_ctrl.sv
// Self-checking bench for msg_frame_ctrl: vector table plus corner-case sequences.
module tb_msg_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_len = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [15:0] beat_count;
    logic        busy;
    logic        msg_done;
    logic        err_zero_len;
`ifdef MSG_FRAME_TLAST_CHECK_EN
    logic        s_tlast = 1'b0;
    logic        err_tlast;
`endif

    int checks = 0;
    int errors = 0;
    int last_len = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;
    beat_t exp_q[$];
    beat_t mon_e;

    typedef struct {
        int          len;
        int          mode;
        logic [31:0] base;
        int          exp_count;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    msg_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_len      (cfg_len),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .beat_count   (beat_count),
        .busy         (busy),
        .msg_done     (msg_done),
        .err_zero_len (err_zero_len)
`ifdef MSG_FRAME_TLAST_CHECK_EN
        ,
        .s_tlast      (s_tlast),
        .err_tlast    (err_tlast)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Scoreboard side: every downstream handshake pops one expected beat.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat at %0t: got data %0h expected none", $time, m_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("beat_data", {32'd0, m_tdata}, {32'd0, mon_e.data});
                chk("beat_last", {63'd0, m_tlast}, {63'd0, mon_e.last});
            end
        end
    end

    // mode 0: always flowing; mode 1: m_tready 1,0,0 repeating with tvalid gaps; mode 2: random.
    task automatic run_msg(input int len, input int mode, input bit bad_tlast,
                           input logic [31:0] base, input int exp_count);
        int  idx;
        int  cyc;
        bit  hs;
        bit  lt;
        bit  exp_et;
        for (int k = 0; k < 20 && !cfg_ready; k++) @(negedge clk);
        chk("cfg_ready_wait", {63'd0, cfg_ready}, 64'd1);
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_len   = 16'(len);
        for (int i = 0; i < len; i++) exp_q.push_back({base + 32'(i), (i == len - 1)});
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        idx = 0;
        cyc = 0;
        exp_et = 1'b0;
        while (idx < len && cyc < len * 4 + 100) begin
            s_tvalid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            m_tready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            s_tdata  = base + 32'(idx);
            lt       = bad_tlast ? (idx == 1) : (idx == len - 1);
`ifdef MSG_FRAME_TLAST_CHECK_EN
            s_tlast  = lt;
`endif
            @(negedge clk);
            chk("pass_tvalid", {63'd0, m_tvalid}, {63'd0, s_tvalid});
            chk("pass_tready", {63'd0, s_tready}, {63'd0, m_tready});
            if (m_tvalid) chk("tlast_level", {63'd0, m_tlast}, {63'd0, (idx == len - 1)});
            if (cyc == 0) begin
                chk("stream_busy", {63'd0, busy}, 64'd1);
                chk("stream_cfg_ready", {63'd0, cfg_ready}, 64'd0);
            end
`ifdef MSG_FRAME_TLAST_CHECK_EN
            chk("err_tlast", {63'd0, err_tlast}, {63'd0, exp_et});
`endif
            hs = s_tvalid && m_tready;
            @(posedge clk); #1;
            exp_et = hs && (lt != (idx == len - 1));
            if (hs) idx++;
            cyc++;
        end
        if (idx < len) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got %0d beats expected %0d", idx, len);
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge clk);
        chk("done_msg_done", {63'd0, msg_done}, 64'd1);
        chk("done_busy", {63'd0, busy}, 64'd1);
        chk("done_cfg_ready", {63'd0, cfg_ready}, 64'd0);
        chk("done_beat_count", {48'd0, beat_count}, 64'(exp_count));
`ifdef MSG_FRAME_TLAST_CHECK_EN
        chk("done_err_tlast", {63'd0, err_tlast}, {63'd0, exp_et});
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_msg_done", {63'd0, msg_done}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        chk("idle_beat_count", {48'd0, beat_count}, 64'(exp_count));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("msg len=%0d mode=%0d beats=%0d cycles=%0d", len, mode, idx, cyc);
        last_len = exp_count;
    endtask

    initial begin
        vecs[0] = '{len: 4, mode: 0, base: 32'h1000_0000, exp_count: 4};
        vecs[1] = '{len: 1, mode: 0, base: 32'h2000_0000, exp_count: 1};
        vecs[2] = '{len: 5, mode: 1, base: 32'h3000_0000, exp_count: 5};
        vecs[3] = '{len: 7, mode: 2, base: 32'h4000_0000, exp_count: 7};
        vecs[4] = '{len: 3, mode: 1, base: 32'h5000_0000, exp_count: 3};
        vecs[5] = '{len: 2, mode: 2, base: 32'h6000_0000, exp_count: 2};

        @(negedge clk);
        chk("rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_msg_done", {63'd0, msg_done}, 64'd0);
        chk("rst_err_zero_len", {63'd0, err_zero_len}, 64'd0);
        chk("rst_beat_count", {48'd0, beat_count}, 64'd0);
        chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int t = 0; t < 6; t++)
            run_msg(vecs[t].len, vecs[t].mode, 1'b0, vecs[t].base, vecs[t].exp_count);

        // Zero-length config is rejected with a single pulse.
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_len   = 16'd0;
        s_tvalid  = 1'b1;
        m_tready  = 1'b1;
        @(negedge clk);
        chk("zero_err_early", {63'd0, err_zero_len}, 64'd0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("zero_err_pulse", {63'd0, err_zero_len}, 64'd1);
        chk("zero_busy", {63'd0, busy}, 64'd0);
        chk("zero_s_tready", {63'd0, s_tready}, 64'd0);
        chk("zero_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("zero_beat_count", {48'd0, beat_count}, 64'(last_len));
        @(posedge clk); #1;
        @(negedge clk);
        chk("zero_err_clear", {63'd0, err_zero_len}, 64'd0);
        chk("zero_busy2", {63'd0, busy}, 64'd0);
        $display("zero-length config checked");
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        run_msg(2, 0, 1'b0, 32'h7000_0000, 2);

        // Reset after 3 of 8 beats abandons the message.
        @(posedge clk); #1;
        cfg_valid = 1'b1;
        cfg_len   = 16'd8;
        for (int i = 0; i < 3; i++) exp_q.push_back({32'h8000_0000 + 32'(i), 1'b0});
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        s_tvalid  = 1'b1;
        m_tready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 32'h8000_0000 + 32'(i);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_beat_count", {48'd0, beat_count}, 64'd0);
        chk("mid_rst_msg_done", {63'd0, msg_done}, 64'd0);
        chk("mid_rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("mid_rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        chk("mid_rst_queue", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge clk);
        chk("post_rst_msg_done", {63'd0, msg_done}, 64'd0);
        $display("mid-message reset checked");
        run_msg(2, 0, 1'b0, 32'h9000_0000, 2);

`ifdef MSG_FRAME_TLAST_CHECK_EN
        // Upstream tlast on beat 2 of 3: mismatch after beats 2 and 3.
        run_msg(3, 0, 1'b1, 32'hA000_0000, 3);
`endif

        // Maximum length exercises the widened terminal compare.
        run_msg(65535, 0, 1'b0, 32'hB000_0000, 65535);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
